// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with pending-bit scoreboard.
package regfile_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 16;

  // A one-entry file would still need a one-bit select, so clamp the width at 1.
  function automatic int addrW(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [addrW(DEPTH_DEF)-1:0] regIdx_t;

endpackage

// File: rtl/regfile_pending_table.sv
// Per-register in-flight flags: set by issue, cleared by write-back, wiped by flush.
module regfile_pending_table
  import regfile_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = addrW(DEPTH)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_setIdx,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_clrIdx,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_idxA,
  input  logic [ADDR_W-1:0] i_idxB,
  output logic              o_pendA,
  output logic              o_pendB,
  output logic              o_anyBusy
);

  logic [DEPTH-1:0] r_pending;

  // The set is written after the clear so a same-edge reserve beats the write-back.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_pending <= '0;
    end else if (i_flush) begin
      r_pending <= '0;
    end else begin
      if (i_clr) r_pending[i_clrIdx] <= 1'b0;
      if (i_set) r_pending[i_setIdx] <= 1'b1;
    end
  end

  assign o_pendA   = (int'(i_idxA) < DEPTH) ? r_pending[i_idxA] : 1'b0;
  assign o_pendB   = (int'(i_idxB) < DEPTH) ? r_pending[i_idxB] : 1'b0;
  assign o_anyBusy = |r_pending;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-to-read bypass, optional zero
// register and a pending-bit scoreboard for read-after-write hazard detection.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  bit ZERO_REG = 1'b0,
  parameter  bit BYPASS   = 1'b1,
  localparam int ADDR_W   = addrW(DEPTH)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] SelectInput,
  input  logic [WIDTH-1:0]  In,
  input  logic [ADDR_W-1:0] SelectA,
  input  logic [ADDR_W-1:0] SelectB,
  output logic [WIDTH-1:0]  A,
  output logic [WIDTH-1:0]  B,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] SelectReserve,
  input  logic              Flush,
  output logic              BusyA,
  output logic              BusyB,
  output logic              AnyBusy
);

  logic [WIDTH-1:0] r_regs [DEPTH];

  logic w_wrLive, w_resLive, w_liveA, w_liveB, w_bypA, w_bypB;
  logic w_pendA, w_pendB;

  // A select is "live" when it names real, writable storage; everything else reads as 0.
  function automatic logic isLive(input logic [ADDR_W-1:0] sel);
    return (int'(sel) < DEPTH) && !(ZERO_REG && (sel == '0));
  endfunction

  assign w_wrLive  = WriteEnable && isLive(SelectInput);
  assign w_resLive = Reserve && isLive(SelectReserve);
  assign w_liveA   = isLive(SelectA);
  assign w_liveB   = isLive(SelectB);
  assign w_bypA    = BYPASS && w_wrLive && (SelectInput == SelectA);
  assign w_bypB    = BYPASS && w_wrLive && (SelectInput == SelectB);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wrLive) begin
      r_regs[SelectInput] <= In;
    end
  end

  // Storage is already zero during reset, so only the bypass path can show data then.
  always_comb begin
    A = '0;
    B = '0;
    if (w_liveA) A = w_bypA ? In : r_regs[SelectA];
    if (w_liveB) B = w_bypB ? In : r_regs[SelectB];
  end

  regfile_pending_table #(.DEPTH(DEPTH)) u_pending (
    .Clock     (Clock),
    .Reset     (Reset),
    .i_set     (w_resLive),
    .i_setIdx  (SelectReserve),
    .i_clr     (w_wrLive),
    .i_clrIdx  (SelectInput),
    .i_flush   (Flush),
    .i_idxA    (SelectA),
    .i_idxB    (SelectB),
    .o_pendA   (w_pendA),
    .o_pendB   (w_pendB),
    .o_anyBusy (AnyBusy)
  );

  assign BusyA = w_liveA && !w_bypA && w_pendA;
  assign BusyB = w_liveB && !w_bypB && w_pendB;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: three configurations share one stimulus stream and are
// checked against an array-based reference model.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic            Clock;
  logic            Reset;
  logic            WriteEnable;
  regIdx_t         SelectInput;
  logic [15:0]     In;
  regIdx_t         SelectA;
  regIdx_t         SelectB;
  logic            Reserve;
  regIdx_t         SelectReserve;
  logic            Flush;

  logic [2:0][15:0] aOut;
  logic [2:0][15:0] bOut;
  logic [2:0]       busyAOut;
  logic [2:0]       busyBOut;
  logic [2:0]       anyOut;

  // cfg0: default, cfg1: no bypass, cfg2: zero register with 12 entries
  int cfgDepth [3] = '{16, 16, 12};
  bit cfgZero  [3] = '{1'b0, 1'b0, 1'b1};
  bit cfgByp   [3] = '{1'b1, 1'b0, 1'b1};

  logic [15:0] mReg  [3][16];
  bit          mPend [3][16];

  typedef struct {
    int          cfg;
    string       tag;
    logic [15:0] a;
    logic [15:0] b;
    logic        busyA;
    logic        busyB;
    logic        any;
  } expect_t;

  expect_t expQ[$];
  int total = 0;
  int bad   = 0;

  regfile_scoreboard #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut0 (
    .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable), .SelectInput(SelectInput),
    .In(In), .SelectA(SelectA), .SelectB(SelectB), .A(aOut[0]), .B(bOut[0]),
    .Reserve(Reserve), .SelectReserve(SelectReserve), .Flush(Flush),
    .BusyA(busyAOut[0]), .BusyB(busyBOut[0]), .AnyBusy(anyOut[0]));

  regfile_scoreboard #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
    .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable), .SelectInput(SelectInput),
    .In(In), .SelectA(SelectA), .SelectB(SelectB), .A(aOut[1]), .B(bOut[1]),
    .Reserve(Reserve), .SelectReserve(SelectReserve), .Flush(Flush),
    .BusyA(busyAOut[1]), .BusyB(busyBOut[1]), .AnyBusy(anyOut[1]));

  regfile_scoreboard #(.WIDTH(16), .DEPTH(12), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut2 (
    .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable), .SelectInput(SelectInput),
    .In(In), .SelectA(SelectA), .SelectB(SelectB), .A(aOut[2]), .B(bOut[2]),
    .Reserve(Reserve), .SelectReserve(SelectReserve), .Flush(Flush),
    .BusyA(busyAOut[2]), .BusyB(busyBOut[2]), .AnyBusy(anyOut[2]));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic bit live(input int k, input int sel);
    return (sel < cfgDepth[k]) && !(cfgZero[k] && sel == 0);
  endfunction

  function automatic bit bypassed(input int k, input int sel);
    return cfgByp[k] && WriteEnable && live(k, int'(SelectInput)) && int'(SelectInput) == sel;
  endfunction

  function automatic logic [15:0] expRead(input int k, input int sel);
    if (!live(k, sel)) return 16'h0;
    if (bypassed(k, sel)) return In;
    return mReg[k][sel];
  endfunction

  function automatic logic expBusy(input int k, input int sel);
    return live(k, sel) && !bypassed(k, sel) && mPend[k][sel];
  endfunction

  function automatic logic expAny(input int k);
    logic r = 1'b0;
    for (int i = 0; i < 16; i++) r = r | mPend[k][i];
    return r;
  endfunction

  task automatic clearModel();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) begin
        mReg[k][i]  = 16'h0;
        mPend[k][i] = 1'b0;
      end
  endtask

  // Applies the rules of one clock edge to the model, using the inputs held across it.
  task automatic updateModel();
    for (int k = 0; k < 3; k++) begin
      if (Flush) begin
        for (int i = 0; i < 16; i++) mPend[k][i] = 1'b0;
      end else begin
        if (WriteEnable && live(k, int'(SelectInput))) mPend[k][int'(SelectInput)] = 1'b0;
        if (Reserve && live(k, int'(SelectReserve))) mPend[k][int'(SelectReserve)] = 1'b1;
      end
      if (WriteEnable && live(k, int'(SelectInput))) mReg[k][int'(SelectInput)] = In;
    end
  endtask

  // Drives one cycle, queues the expected outputs for every configuration, then
  // advances the model across the edge. Reset assertion lands mid-cycle on purpose.
  task automatic applyStimulus(input logic we, input int si, input logic [15:0] din,
                               input int sa, input int sb, input logic res, input int sr,
                               input logic fl, input logic rstn, input string tag);
    expect_t e;
    WriteEnable   = we;
    SelectInput   = regIdx_t'(si);
    In            = din;
    SelectA       = regIdx_t'(sa);
    SelectB       = regIdx_t'(sb);
    Reserve       = res;
    SelectReserve = regIdx_t'(sr);
    Flush         = fl;
    if (!rstn && Reset) #2;
    Reset = rstn;
    if (!rstn) clearModel();
    for (int k = 0; k < 3; k++) begin
      e.cfg   = k;
      e.tag   = tag;
      e.a     = expRead(k, sa);
      e.b     = expRead(k, sb);
      e.busyA = expBusy(k, sa);
      e.busyB = expBusy(k, sb);
      e.any   = expAny(k);
      expQ.push_back(e);
    end
    @(posedge Clock);
    if (Reset) updateModel();
    #1;
  endtask

  task automatic checkOutput(input string name, input int cfg,
                             input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s cfg%0d got=%h want=%h", name, cfg, got, want);
    end
  endtask

  // Monitor: every falling edge, drain whatever the driver queued for this cycle.
  initial begin
    expect_t e;
    forever begin
      @(negedge Clock);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.tag, ".A"},     e.cfg, aOut[e.cfg],              e.a);
        checkOutput({e.tag, ".B"},     e.cfg, bOut[e.cfg],              e.b);
        checkOutput({e.tag, ".BusyA"}, e.cfg, {15'h0, busyAOut[e.cfg]}, {15'h0, e.busyA});
        checkOutput({e.tag, ".BusyB"}, e.cfg, {15'h0, busyBOut[e.cfg]}, {15'h0, e.busyB});
        checkOutput({e.tag, ".Any"},   e.cfg, {15'h0, anyOut[e.cfg]},   {15'h0, e.any});
      end
    end
  end

  initial begin
    int si, sa, sb, sr;
    WriteEnable = 1'b0; SelectInput = '0; In = '0; SelectA = '0; SelectB = '0;
    Reserve = 1'b0; SelectReserve = '0; Flush = 1'b0; Reset = 1'b0;
    clearModel();
    @(posedge Clock);
    #1;

    applyStimulus(0, 0,  16'h0,    3,  9, 0, 0, 0, 0, "reset");
    applyStimulus(0, 0,  16'h0,    3,  9, 0, 0, 0, 1, "postReset");
    applyStimulus(1, 5,  16'd37,   0,  0, 0, 0, 0, 1, "write5");
    applyStimulus(0, 0,  16'd42,   5,  0, 0, 0, 0, 1, "read5");
    applyStimulus(0, 0,  16'd42,  12,  0, 0, 0, 0, 1, "read12");
    applyStimulus(1, 7,  16'h1234, 7,  0, 0, 0, 0, 1, "bypass7");
    applyStimulus(0, 0,  16'h0,    7,  0, 0, 0, 0, 1, "after7");
    applyStimulus(0, 0,  16'h0,    0,  0, 1, 4, 0, 1, "reserve4");
    applyStimulus(0, 0,  16'h0,    0,  4, 0, 0, 0, 1, "busy4");
    applyStimulus(1, 4,  16'h0444, 0,  4, 0, 0, 0, 1, "wb4");
    applyStimulus(0, 0,  16'h0,    0,  4, 0, 0, 0, 1, "after4");
    applyStimulus(1, 6,  16'h0666, 6,  0, 1, 6, 0, 1, "resWr6");
    applyStimulus(0, 0,  16'h0,    6,  6, 0, 0, 0, 1, "check6");
    applyStimulus(0, 0,  16'h0,    6,  2, 1, 2, 1, 1, "flushRes2");
    applyStimulus(0, 0,  16'h0,    6,  2, 0, 0, 0, 1, "afterFlush");
    applyStimulus(1, 0,  16'hFFFF, 0,  0, 1, 0, 0, 1, "write0");
    applyStimulus(0, 0,  16'h0,    0, 13, 0, 0, 0, 1, "read0");
    applyStimulus(1, 13, 16'hBEEF, 13, 5, 1, 13, 0, 1, "write13");
    applyStimulus(0, 0,  16'h0,   13,  5, 0, 0, 0, 1, "after13");
    applyStimulus(0, 0,  16'h0,    0,  0, 1, 9, 0, 1, "res9");
    applyStimulus(1, 9,  16'hCAFE, 9,  6, 0, 0, 0, 0, "midReset");
    applyStimulus(0, 0,  16'h0,    9,  6, 0, 0, 0, 1, "afterReset");

    for (int n = 0; n < 600; n++) begin
      si = int'($urandom_range(0, 15));
      sa = ($urandom_range(0, 2) == 0) ? si : int'($urandom_range(0, 15));
      sb = ($urandom_range(0, 2) == 0) ? si : int'($urandom_range(0, 15));
      sr = ($urandom_range(0, 3) == 0) ? si : int'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), si, 16'($urandom), sa, sb,
                    1'($urandom_range(0, 2) == 0), sr, 1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 49) != 0), "rand");
    end

    @(negedge Clock);
    #1;
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain pending=%0d want=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
